// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: tracker entry layout,
// stage numbering and the ready-stage normalisation helper.
package hazard_pkg;

  localparam int unsigned FWD_REGFILE = 0;

  // Wide enough for any ready-stage value up to 15 tracked stages.
  localparam int unsigned READY_W = 4;

  localparam logic [READY_W-1:0] STAGE_EX  = 4'd1;
  localparam logic [READY_W-1:0] STAGE_MEM = 4'd2;
  localparam logic [READY_W-1:0] STAGE_WB  = 4'd3;

  typedef struct packed {
    logic               valid;
    logic [4:0]         rd;
    logic [READY_W-1:0] ready_stage;
  } tracker_entry_t;

  // A ready stage of 0 means "available after EX"; anything past the last
  // tracked stage is treated as available at the last stage.
  function automatic logic [READY_W-1:0] clamp_ready(input logic [READY_W-1:0] rs,
                                                     input logic [READY_W-1:0] last_stage);
    if (rs == '0)
      return STAGE_EX;
    else if (rs > last_stage)
      return last_stage;
    else
      return rs;
  endfunction

endpackage

// File: rtl/hazard_port_lookup.sv
// Youngest-producer search for one operand port: returns the forwarding stage
// and whether that producer's result is not yet available.
module hazard_port_lookup
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  tracker_entry_t   i_entries [1:NUM_STAGES],
  input  logic [4:0]       i_read_reg,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_not_ready
);

  logic w_found;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave it unassigned and infer a latch.
  always_comb begin
    o_sel       = SEL_W'(FWD_REGFILE);
    o_not_ready = 1'b0;
    w_found     = 1'b0;
    for (int s = 1; s <= NUM_STAGES; s++) begin
      if (!w_found && i_entries[s].valid && (i_entries[s].rd != 5'd0) &&
          (i_entries[s].rd == i_read_reg)) begin
        w_found     = 1'b1;
        o_sel       = SEL_W'(s);
        o_not_ready = (i_entries[s].ready_stage > READY_W'(s));
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Tracks in-flight register writes after ID, selects operand bypass sources and
// raises load-use stalls. Optional stall counter: define PIPELINE_HAZARD_PERF_EN.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_STAGES     = 3,
  parameter int SEL_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_hold,
  input  logic                        i_flush,
  input  logic                        i_issue_valid,
  input  logic                        i_issue_reg_write,
  input  logic [4:0]                  i_issue_rd,
  input  logic [SEL_W-1:0]            i_issue_ready_stage,
  input  logic [5*NUM_READ_PORTS-1:0] i_read_reg,
  input  logic [NUM_READ_PORTS-1:0]   i_read_used,
  output logic [SEL_W*NUM_READ_PORTS-1:0] o_fwd_sel,
  output logic                        o_stall
`ifdef PIPELINE_HAZARD_PERF_EN
  ,
  output logic [31:0]                 o_stall_cycles
`endif
);

  tracker_entry_t                r_stage [1:NUM_STAGES];
  tracker_entry_t                w_new_entry;
  logic [NUM_READ_PORTS-1:0]     w_not_ready;
  logic                          w_issue_tracked;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    hazard_port_lookup #(
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W)
    ) u_lookup (
      .i_entries   (r_stage),
      .i_read_reg  (i_read_reg[5*p +: 5]),
      .o_sel       (o_fwd_sel[SEL_W*p +: SEL_W]),
      .o_not_ready (w_not_ready[p])
    );
  end

  // Unused ports may still report a select, but never hold up ID.
  assign o_stall = i_issue_valid && !i_flush && |(i_read_used & w_not_ready);

  assign w_issue_tracked = i_issue_valid && i_issue_reg_write && (i_issue_rd != 5'd0) &&
                           !o_stall && !i_flush;

  always_comb begin
    w_new_entry             = '0;
    w_new_entry.valid       = w_issue_tracked;
    w_new_entry.rd          = i_issue_rd;
    w_new_entry.ready_stage = clamp_ready(READY_W'(i_issue_ready_stage), READY_W'(NUM_STAGES));
  end

  // NOTE: the tracker is a small register array, not a RAM, so the whole thing
  // is cleared on reset; a stale valid bit would create a phantom dependency.
  // NOTE: state uses non-blocking assignments so every stage shifts from the
  // pre-edge value of its neighbour, regardless of loop order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= NUM_STAGES; s++) r_stage[s] <= '0;
    end else if (!i_hold) begin
      for (int s = NUM_STAGES; s >= 2; s--) r_stage[s] <= r_stage[s-1];
      r_stage[1] <= w_new_entry;
    end
  end

`ifdef PIPELINE_HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (o_stall && !i_hold && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed self-checking bench for pipeline_hazard_unit (2 read ports, 3 stages).
`timescale 1ns/1ps
module tb_pipeline_hazard_unit;

  localparam int NRP   = 2;
  localparam int NST   = 3;
  localparam int SEL_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hold, flush;
  logic                 issue_valid, issue_reg_write;
  logic [4:0]           issue_rd;
  logic [SEL_W-1:0]     issue_ready_stage;
  logic [5*NRP-1:0]     read_reg;
  logic [NRP-1:0]       read_used;
  logic [SEL_W*NRP-1:0] fwd_sel;
  logic                 stall;
`ifdef PIPELINE_HAZARD_PERF_EN
  logic [31:0]          stall_cycles;
  logic [31:0]          cnt_before;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_unit #(
    .NUM_READ_PORTS (NRP),
    .NUM_STAGES     (NST),
    .SEL_W          (SEL_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_hold              (hold),
    .i_flush             (flush),
    .i_issue_valid       (issue_valid),
    .i_issue_reg_write   (issue_reg_write),
    .i_issue_rd          (issue_rd),
    .i_issue_ready_stage (issue_ready_stage),
    .i_read_reg          (read_reg),
    .i_read_used         (read_used),
    .o_fwd_sel           (fwd_sel),
    .o_stall             (stall)
`ifdef PIPELINE_HAZARD_PERF_EN
    ,
    .o_stall_cycles      (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then let combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic wr, input logic [4:0] rd, input logic [1:0] rs);
    issue_valid       = v;
    issue_reg_write   = wr;
    issue_rd          = rd;
    issue_ready_stage = rs;
    #1;
  endtask

  task automatic reads(input logic [4:0] r0, input logic u0, input logic [4:0] r1, input logic u1);
    read_reg  = {r1, r0};
    read_used = {u1, u0};
    #1;
  endtask

  task automatic drain();
    issue(1'b0, 1'b0, 5'd0, 2'd0);
    reads(5'd0, 1'b0, 5'd0, 1'b0);
    repeat (NST) step();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    issue(1'b0, 1'b0, 5'd0, 2'd0);
    reads(5'd0, 1'b0, 5'd0, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("reset_fwd", fwd_sel, 0);
    check("reset_stall", stall, 0);
`ifdef PIPELINE_HAZARD_PERF_EN
    check("reset_cnt", stall_cycles, 0);
`endif

    // ALU x5 then dependent reader
    issue(1'b1, 1'b1, 5'd5, 2'd1);
    step();
    issue(1'b1, 1'b1, 5'd8, 2'd1);
    reads(5'd5, 1'b1, 5'd0, 1'b0);
    check("alu_fwd_ex", fwd_sel[1:0], 1);
    check("alu_stall", stall, 0);
    step();
    check("alu_fwd_mem", fwd_sel[1:0], 2);
    drain();

    // Load x6, dependent on port 1: one stall then forward from MEM
    issue(1'b1, 1'b1, 5'd6, 2'd2);
    step();
    issue(1'b1, 1'b1, 5'd9, 2'd1);
    reads(5'd0, 1'b0, 5'd6, 1'b1);
    check("lu_stall", stall, 1);
    check("lu_fwd_ex", fwd_sel[3:2], 1);
    step();
    check("lu_bubble", dut.r_stage[1].valid, 0);
    check("lu_stall_gone", stall, 0);
    check("lu_fwd_mem", fwd_sel[3:2], 2);
    step();
    check("lu_consumer_in_ex", dut.r_stage[1].rd, 9);
    drain();

    // Youngest match wins
    issue(1'b1, 1'b1, 5'd7, 2'd1);
    step();
    issue(1'b1, 1'b1, 5'd7, 2'd1);
    step();
    issue(1'b1, 1'b0, 5'd0, 2'd0);
    reads(5'd7, 1'b1, 5'd0, 1'b0);
    check("young_fwd", fwd_sel[1:0], 1);
    check("young_stall", stall, 0);
    drain();
    issue(1'b1, 1'b1, 5'd7, 2'd1);
    step();
    issue(1'b1, 1'b1, 5'd7, 2'd2);
    step();
    issue(1'b1, 1'b0, 5'd0, 2'd0);
    reads(5'd7, 1'b1, 5'd0, 1'b0);
    check("young_unready_fwd", fwd_sel[1:0], 1);
    check("young_unready_stall", stall, 1);
    drain();

    // x0 never tracked, never forwarded
    issue(1'b1, 1'b1, 5'd0, 2'd2);
    step();
    check("x0_not_tracked", dut.r_stage[1].valid, 0);
    issue(1'b1, 1'b0, 5'd0, 2'd0);
    reads(5'd0, 1'b1, 5'd0, 1'b1);
    check("x0_fwd", fwd_sel, 0);
    check("x0_stall", stall, 0);
    drain();

    // Unused port on unready match: select reported, no stall
    issue(1'b1, 1'b1, 5'd10, 2'd2);
    step();
    issue(1'b1, 1'b0, 5'd0, 2'd0);
    reads(5'd10, 1'b0, 5'd0, 1'b0);
    check("unused_fwd", fwd_sel[1:0], 1);
    check("unused_stall", stall, 0);
    drain();

    // Ready stage 0 behaves as 1
    issue(1'b1, 1'b1, 5'd15, 2'd0);
    step();
    issue(1'b1, 1'b0, 5'd0, 2'd0);
    reads(5'd0, 1'b0, 5'd15, 1'b1);
    check("rs0_fwd", fwd_sel[3:2], 1);
    check("rs0_stall", stall, 0);
    drain();

    // Hold during pending load-use
    issue(1'b1, 1'b1, 5'd6, 2'd2);
    step();
    issue(1'b1, 1'b1, 5'd9, 2'd1);
    reads(5'd0, 1'b0, 5'd6, 1'b1);
    check("hold_pre_stall", stall, 1);
`ifdef PIPELINE_HAZARD_PERF_EN
    cnt_before = stall_cycles;
`endif
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_stall_%0d", i), stall, 1);
      check($sformatf("hold_fwd_%0d", i), fwd_sel[3:2], 1);
      check($sformatf("hold_rd_%0d", i), dut.r_stage[1].rd, 6);
`ifdef PIPELINE_HAZARD_PERF_EN
      check($sformatf("hold_cnt_%0d", i), stall_cycles, cnt_before);
`endif
    end
    hold = 1'b0;
    #1;
    check("hold_release_stall", stall, 1);
    step();
    check("hold_after_stall", stall, 0);
    check("hold_after_fwd", fwd_sel[3:2], 2);
`ifdef PIPELINE_HAZARD_PERF_EN
    check("hold_after_cnt", stall_cycles, cnt_before + 32'd1);
`endif
    drain();

    // Flush squashes both stall and tracking
    issue(1'b1, 1'b1, 5'd6, 2'd2);
    step();
    issue(1'b1, 1'b1, 5'd14, 2'd1);
    reads(5'd6, 1'b1, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_stall", stall, 0);
    step();
    flush = 1'b0;
    check("flush_bubble", dut.r_stage[1].valid, 0);
    drain();

    // Reset with all stages valid
    issue(1'b1, 1'b1, 5'd11, 2'd1);
    step();
    issue(1'b1, 1'b1, 5'd12, 2'd1);
    step();
    issue(1'b1, 1'b1, 5'd13, 2'd2);
    step();
    issue(1'b1, 1'b0, 5'd0, 2'd0);
    reads(5'd13, 1'b1, 5'd11, 1'b1);
    check("full_fwd", fwd_sel, 4'b1101);
    check("full_stall", stall, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_fwd", fwd_sel, 0);
    check("rst_stall", stall, 0);
    reads(5'd12, 1'b1, 5'd12, 1'b1);
    check("rst_fwd_x12", fwd_sel, 0);
`ifdef PIPELINE_HAZARD_PERF_EN
    check("rst_cnt", stall_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised successor to the two-port EX/MEM forwarding logic: it tracks every in-flight register write in an internal shift register that mirrors the pipeline stages after ID. For each of NUM_READ_PORTS operands it selects the youngest producing stage. When the producer's result does not exist yet (load-use, multi-cycle op), it raises a stall and inserts a bubble. It sits beside the ID stage and drives the operand bypass muxes and the ID/IF hold logic.

## Interface
- NUM_READ_PORTS, 2: operand ports looked up in parallel.
- NUM_STAGES, 3: tracked stages after ID (1 = EX, 2 = MEM, 3 = WB).
- SEL_W, $clog2(NUM_STAGES+1): width of a forwarding select.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global pipeline freeze (e.g. memory wait); the tracker does not shift.
- flush  in  1  the instruction in ID is squashed this cycle.
- issue_valid  in  1  ID holds a valid instruction.
- issue_reg_write  in  1  the ID instruction writes rd.
- issue_rd  in  5  destination register of the ID instruction.
- issue_ready_stage  in  SEL_W  first stage whose output carries the result (ALU = 1, load = 2, up to NUM_STAGES).
- read_reg  in  5*NUM_READ_PORTS  source registers; port p is read_reg[5p+4:5p].
- read_used  in  NUM_READ_PORTS  port p is actually consumed.
- fwd_sel  out  SEL_W*NUM_READ_PORTS  per port: 0 = register file, s = output of stage s.
- stall  out  1  ID cannot advance; IF/ID hold and stage 1 receives a bubble.

## Operation
- Tracker entry per stage s = 1..NUM_STAGES holds {valid, rd, ready_stage}.
- Lookup for port p, combinational:
  - A stage s matches when entry valid, rd != 0, and rd == read_reg[p].
  - The lowest (youngest) matching s wins.
  - fwd_sel[p] = s of the winner, else 0.
  - A port with read_used[p] = 0 still reports fwd_sel but never causes a stall.
- stall = issue_valid && !flush && OR over p of (read_used[p] && winner exists && winner.ready_stage > s).
  - An older ready match does not override a younger unready one.
- Shift on each rising edge when hold = 0:
  - stage[s] <= stage[s-1] for s >= 2; stage NUM_STAGES retires and is dropped.
  - stage[1] <= {1, issue_rd, issue_ready_stage} iff issue_valid && issue_reg_write && issue_rd != 0 && !stall && !flush; otherwise invalid (bubble).
- hold = 1: all entries are kept; outputs re-evaluate on the unchanged state.
- Precedence: rst > hold > flush > stall.
- A rd of x0 is never tracked. A read of x0 always gives fwd_sel 0.
- issue_ready_stage of 0 is treated as 1. A value above NUM_STAGES is clamped to NUM_STAGES.

## Timing
- fwd_sel and stall are combinational from the current tracker state and ID inputs, with zero-cycle latency.
- Tracker latency: a non-stalled issue becomes visible as stage 1 one cycle later.
- Load-use with ready_stage 2 and a dependent instruction immediately behind it:
  - exactly 1 stall cycle;
  - the consumer then gets fwd_sel = 2.
- Reset: all entries invalid. fwd_sel = 0 and stall = 0 from the first cycle after rst. stall_cycles = 0.
- rst asserted mid-operation drops all in-flight entries at the next edge. There is no partial state.

## Configuration
- PIPELINE_HAZARD_PERF_EN defined:
  - Extra output stall_cycles, out, 32 bits: counts edges where stall && !hold.
  - Saturates at 32'hFFFF_FFFF and is cleared by rst.
- Not defined: the port and the counter are absent, with no other behavioural difference.

## Structure
- Package hazard_pkg holds:
  - FWD_REGFILE = 0;
  - the tracker entry typedef {valid, rd[4:0], ready_stage};
  - the STAGE_EX = 1, STAGE_MEM = 2, STAGE_WB = 3 constants.
- One sub-module, hazard_port_lookup: the per-port youngest-match priority search returning {sel, not_ready}. It is instantiated NUM_READ_PORTS times via generate.

## Test plan
- ALU x5 issued, next instruction reads x5 on port 0 → fwd_sel[0] = 1 and stall = 0 in that cycle; one cycle later fwd_sel[0] = 2.
- Load x6 (ready_stage 2), next instruction reads x6 on port 1:
  - stall = 1 for exactly 1 cycle;
  - then fwd_sel[1] = 2 with stall = 0;
  - the tracker shows a bubble in stage 1.
- x7 written by stage 2 (ready) and by stage 1 (ready) → fwd_sel = 1. With stage 1 an unready load → stall = 1, not a forward from stage 2.
- Writes to x0 and reads of x0 → never tracked, fwd_sel = 0, stall = 0. A read with read_used = 0 on an unready match → stall = 0.
- hold held 3 cycles during a pending load-use:
  - tracker and outputs unchanged;
  - stall_cycles does not advance (PIPELINE_HAZARD_PERF_EN);
  - after hold drops, the normal 1-cycle stall follows.
- rst asserted with all stages valid → next cycle fwd_sel = 0 and stall = 0 for every read. A flush with a valid issue → stage 1 bubble.
